lcd_char_scheduler: RTL and testbench

Sequences character writes into the LCD driver FSM and shares it between two requesters: the Morse decoder (port A) and the system message source (port B, priority). Accepted characters are buffered in a small FIFO, issued one at a time using the driver's WRITE/WAITING/WRITING handshake, and counted per display line. It sits between the decode path and the LCD driver, and is the only block that drives the driver's EN, CHAR and WRITE inputs.

---
 rtl/lcd_pkg.sv | 19 +
 rtl/char_fifo.sv | 73 +++++++
 rtl/lcd_char_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_lcd_char_scheduler.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD character path: scheduler state
// encoding, display geometry and the driver write timeout.
package lcd_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    BUSY  = 3'd3,
    DRAIN = 3'd4
  } sched_state_t;

  localparam int LCD_COLS_DEFAULT  = 16;
  // Must outlast the driver's data-write plus pulse-wait (~16.4k cycles).
  localparam int LCD_WRITE_TIMEOUT = 32767;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO with combinational head output; push when full and pop
// when empty are ignored, a simultaneous push and pop keeps the count.
module char_fifo
  import lcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full     = (count_r == CNT_FULL);
  assign empty    = (count_r == CNT_ZERO);
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Qualify requests against the current occupancy.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lcd_char_scheduler.sv
// Arbitrates decoder (A) and message-source (B, priority) characters into a
// FIFO and issues them one at a time to the LCD driver, tracking the column.
module lcd_char_scheduler
  import lcd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int COLS    = LCD_COLS_DEFAULT,
  parameter int TIMEOUT = LCD_WRITE_TIMEOUT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [7:0]                 A_CHAR,
  input  logic                       A_VALID,
  output logic                       A_READY,
  input  logic [7:0]                 B_CHAR,
  input  logic                       B_VALID,
  output logic                       B_READY,
  output logic                       LCD_EN,
  output logic [7:0]                 LCD_CHAR,
  output logic                       LCD_WRITE,
  input  logic                       LCD_WAITING,
  input  logic                       LCD_WRITING,
  output logic [$clog2(COLS)-1:0]    COL,
  output logic                       LINE_FULL,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       ERR
);

  localparam int CW = $clog2(COLS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] COL_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] COL_ONE    = CW'(1'b1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1'b1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);

  sched_state_t   state_r;
  sched_state_t   next_state_s;

  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [7:0]     fifo_head_s;
  logic           a_ready_s;
  logic           b_ready_s;
  logic           push_s;
  logic [7:0]     push_data_s;
  logic           pop_s;
  logic           done_s;
  logic           timing_s;
  logic           timeout_s;

  logic           en_r;
  logic [7:0]     char_r;
  logic           write_r;
  logic [CW-1:0]  col_r;
  logic           line_full_r;
  logic           err_r;
  logic [TW-1:0]  timer_r;

  char_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (COUNT)
  );

  // Ingress arbitration; both READYs are forced low while reset is held.
  always_comb begin
    b_ready_s   = !RST && !fifo_full_s;
    a_ready_s   = b_ready_s && !B_VALID;
    push_s      = (B_VALID && b_ready_s) || (A_VALID && a_ready_s);
    push_data_s = B_VALID ? B_CHAR : A_CHAR;
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; a timeout in BUSY/DRAIN abandons the character.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      INIT: begin
        if (LCD_WAITING) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = INIT;
        end
      end
      IDLE: begin
        if (pop_s) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: next_state_s = BUSY;
      BUSY: begin
        if (timeout_s) begin
          next_state_s = INIT;
        end else if (LCD_WRITING) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = BUSY;
        end
      end
      DRAIN: begin
        if (timeout_s) begin
          next_state_s = INIT;
        end else if (done_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: next_state_s = INIT;
    endcase
  end

  // FSM output decode: pop, completion and timeout strobes.
  always_comb begin
    pop_s     = 1'b0;
    done_s    = 1'b0;
    timing_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        pop_s = !fifo_empty_s && LCD_WAITING;
      end
      BUSY: begin
        timing_s  = 1'b1;
        timeout_s = (timer_r == TIMER_MAX);
      end
      DRAIN: begin
        timing_s  = 1'b1;
        timeout_s = (timer_r == TIMER_MAX);
        done_s    = !timeout_s && LCD_WAITING;
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // Driver enable rises on the first clock out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_r <= 1'b0;
    end else begin
      en_r <= 1'b1;
    end
  end

  // Character register holds from pop to next pop; WRITE marks the ISSUE cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      char_r  <= 8'h00;
      write_r <= 1'b0;
    end else begin
      write_r <= pop_s;
      if (pop_s) begin
        char_r <= fifo_head_s;
      end
    end
  end

  // Write watchdog: cleared on entry to ISSUE, runs through BUSY and DRAIN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_r <= TIMER_ZERO;
    end else if (pop_s) begin
      timer_r <= TIMER_ZERO;
    end else if (timing_s && !timeout_s) begin
      timer_r <= timer_r + TIMER_ONE;
    end
  end

  // Column tracking with a single-cycle wrap pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col_r       <= COL_ZERO;
      line_full_r <= 1'b0;
    end else begin
      line_full_r <= 1'b0;
      if (done_s) begin
        if (col_r == COL_LAST) begin
          col_r       <= COL_ZERO;
          line_full_r <= 1'b1;
        end else begin
          col_r <= col_r + COL_ONE;
        end
      end
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end
  end

  assign A_READY   = a_ready_s;
  assign B_READY   = b_ready_s;
  assign LCD_EN    = en_r;
  assign LCD_CHAR  = char_r;
  assign LCD_WRITE = write_r;
  assign COL       = col_r;
  assign LINE_FULL = line_full_r;
  assign ERR       = err_r;

endmodule

// File: tb/tb_lcd_char_scheduler.sv
// Directed bench for lcd_char_scheduler with a behavioural LCD driver model
// (20-cycle write: 10 cycles WRITING, 10 cycles settling).
module tb_lcd_char_scheduler;
  import lcd_pkg::*;

  localparam int TO       = 32767;
  localparam int M_NORMAL = 0;
  localparam int M_HOLD   = 1;
  localparam int M_STUCK  = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] A_CHAR, B_CHAR;
  logic       A_VALID, B_VALID;
  logic       A_READY, B_READY;
  logic       LCD_EN, LCD_WRITE, LCD_WAITING, LCD_WRITING;
  logic [7:0] LCD_CHAR;
  logic [3:0] COL;
  logic       LINE_FULL, ERR;
  logic [3:0] COUNT;

  int n_cmp = 0;
  int n_fail = 0;

  int drv_mode = M_HOLD;
  int phase = 0;
  int cnt = 0;
  int stab_err = 0;
  int wr_high = 0;
  int lf_count = 0;
  int lf_col = 0;
  int lf_writes = 0;
  logic [7:0] held;
  logic [7:0] wr_log[$];

  lcd_char_scheduler dut (
    .CLK(CLK), .RST(RST),
    .A_CHAR(A_CHAR), .A_VALID(A_VALID), .A_READY(A_READY),
    .B_CHAR(B_CHAR), .B_VALID(B_VALID), .B_READY(B_READY),
    .LCD_EN(LCD_EN), .LCD_CHAR(LCD_CHAR), .LCD_WRITE(LCD_WRITE),
    .LCD_WAITING(LCD_WAITING), .LCD_WRITING(LCD_WRITING),
    .COL(COL), .LINE_FULL(LINE_FULL), .COUNT(COUNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Driver model: reacts to LCD_WRITE seen just after a rising edge.
  initial begin
    LCD_WAITING = 1'b0;
    LCD_WRITING = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (LCD_WRITE) begin
        wr_log.push_back(LCD_CHAR);
        wr_high++;
      end
      if (LINE_FULL) begin
        lf_count++;
        lf_col = int'(COL);
        lf_writes = wr_log.size();
      end
      case (phase)
        0: begin
          if (LCD_WRITE && drv_mode != M_HOLD) begin
            held = LCD_CHAR;
            cnt = 0;
            LCD_WAITING = 1'b0;
            if (drv_mode == M_STUCK) begin
              phase = 3;
              LCD_WRITING = 1'b0;
            end else begin
              phase = 1;
              LCD_WRITING = 1'b1;
            end
          end else begin
            LCD_WAITING = (drv_mode != M_HOLD);
          end
        end
        1: begin
          cnt++;
          if (LCD_CHAR !== held) stab_err++;
          if (cnt == 10) begin
            phase = 2;
            LCD_WRITING = 1'b0;
          end
        end
        2: begin
          cnt++;
          if (cnt == 20) begin
            phase = 0;
            LCD_WAITING = (drv_mode != M_HOLD);
          end
        end
        default: begin
          if (drv_mode != M_STUCK) begin
            phase = 0;
            LCD_WAITING = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
  endtask

  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      #1;
      if (phase == 0 && LCD_WAITING && COUNT == 4'd0 && !LCD_WRITE) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) tick();
  endtask

  task automatic push_wait(input bit use_b, input logic [7:0] c, output bit ok);
    ok = 1'b0;
    if (use_b) begin
      B_CHAR = c;
      B_VALID = 1'b1;
    end else begin
      A_CHAR = c;
      A_VALID = 1'b1;
    end
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (use_b ? B_READY : A_READY) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    A_VALID = 1'b0;
    B_VALID = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int k;
    drv_mode = M_HOLD;
    RST = 1'b1;
    A_CHAR = 8'h11; B_CHAR = 8'h22;
    A_VALID = 1'b1; B_VALID = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({A_READY, B_READY, LCD_EN, LCD_WRITE, LINE_FULL, ERR} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {A_READY, B_READY, LCD_EN, LCD_WRITE, LINE_FULL, ERR});
    end
    n_cmp++;
    if ({LCD_CHAR, COL, COUNT} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_regs: got char=%h col=%0d count=%0d expected 0/0/0", LCD_CHAR, COL, COUNT);
    end
    A_VALID = 1'b0; B_VALID = 1'b0;
    RST = 1'b0;
    #1;
    n_cmp++;
    if (LCD_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL en_before_edge: got %b expected 0", LCD_EN);
    end
    tick();
    n_cmp++;
    if (LCD_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL en_after_edge: got %b expected 1", LCD_EN);
    end
    push_wait(1'b1, 8'h5A, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL init_push: got not-accepted expected accepted");
    end
    repeat (5) tick();
    #1;
    n_cmp++;
    if (wr_high != 0 || COUNT !== 4'd1) begin
      n_fail++;
      $display("FAIL init_hold: got writes=%0d count=%0d expected 0/1", wr_high, COUNT);
    end
    drv_mode = M_NORMAL;
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      if (LCD_WAITING) break;
    end
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      k++;
      if (LCD_WRITE) break;
    end
    n_cmp++;
    if (k != 2) begin
      n_fail++;
      $display("FAIL init_to_issue: got %0d edges expected 2", k);
    end
    n_cmp++;
    if (LCD_CHAR !== 8'h5A) begin
      n_fail++;
      $display("FAIL init_char: got %h expected 5a", LCD_CHAR);
    end
    wait_quiet(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL init_complete: got timeout expected completion");
    end
  endtask

  task automatic test_single();
    int extra;
    int bad;
    apply_reset();
    tick();
    A_CHAR = 8'h45; A_VALID = 1'b1;
    #1;
    n_cmp++;
    if (A_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 1", A_READY);
    end
    tick();
    A_VALID = 1'b0;
    n_cmp++;
    if (COUNT !== 4'd1 || LCD_WRITE !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got count=%0d write=%b expected 1/0", COUNT, LCD_WRITE);
    end
    tick();
    n_cmp++;
    if (LCD_WRITE !== 1'b1 || LCD_CHAR !== 8'h45 || COUNT !== 4'd0 || COL !== 4'd0) begin
      n_fail++;
      $display("FAIL single_issue: got write=%b char=%h count=%0d col=%0d expected 1/45/0/0",
               LCD_WRITE, LCD_CHAR, COUNT, COL);
    end
    tick();
    n_cmp++;
    if (LCD_WRITE !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: got %b expected 0", LCD_WRITE);
    end
    extra = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (LCD_WRITE) extra++;
      if (LCD_CHAR !== 8'h45) bad++;
    end
    n_cmp++;
    if (extra != 0 || bad != 0 || stab_err != 0) begin
      n_fail++;
      $display("FAIL single_stable: got extra=%0d unstable=%0d drv_unstable=%0d expected 0/0/0",
               extra, bad, stab_err);
    end
    n_cmp++;
    if (COL !== 4'd1) begin
      n_fail++;
      $display("FAIL single_col: got %0d expected 1", COL);
    end
  endtask

  task automatic test_priority();
    bit ok;
    wr_log.delete();
    A_CHAR = 8'h41; B_CHAR = 8'h42;
    A_VALID = 1'b1; B_VALID = 1'b1;
    #1;
    n_cmp++;
    if ({B_READY, A_READY} !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_ready: got B,A=%b expected 10", {B_READY, A_READY});
    end
    tick();
    B_VALID = 1'b0;
    #1;
    n_cmp++;
    if (A_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_a_ready: got %b expected 1", A_READY);
    end
    tick();
    A_VALID = 1'b0;
    wait_quiet(ok);
    n_cmp++;
    if (!ok || wr_log.size() != 2) begin
      n_fail++;
      $display("FAIL prio_count: got %0d writes expected 2", wr_log.size());
    end else begin
      n_cmp++;
      if (wr_log[0] !== 8'h42 || wr_log[1] !== 8'h41) begin
        n_fail++;
        $display("FAIL prio_order: got %h,%h expected 42,41", wr_log[0], wr_log[1]);
      end
    end
    n_cmp++;
    if (COL !== 4'd3) begin
      n_fail++;
      $display("FAIL prio_col: got %0d expected 3", COL);
    end
  endtask

  task automatic test_full();
    bit ok;
    int bad;
    bit seen;
    logic [7:0] c;
    drv_mode = M_HOLD;
    repeat (2) tick();
    wr_log.delete();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      c = 8'h30 + 8'(i);
      push_wait(1'b1, c, ok);
      if (!ok) bad++;
    end
    n_cmp++;
    if (bad != 0 || COUNT !== 4'd8) begin
      n_fail++;
      $display("FAIL full_fill: got rejects=%0d count=%0d expected 0/8", bad, COUNT);
    end
    B_CHAR = 8'h38; B_VALID = 1'b1;
    #1;
    n_cmp++;
    if ({A_READY, B_READY} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_ready: got A,B=%b expected 00", {A_READY, B_READY});
    end
    repeat (3) tick();
    n_cmp++;
    if (COUNT !== 4'd8) begin
      n_fail++;
      $display("FAIL full_hold: got %0d expected 8", COUNT);
    end
    drv_mode = M_NORMAL;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (COUNT !== 4'd8) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen || COUNT !== 4'd7 || B_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL full_first_pop: got count=%0d ready=%b expected 7/1", COUNT, B_READY);
    end
    tick();
    B_VALID = 1'b0;
    n_cmp++;
    if (COUNT !== 4'd8) begin
      n_fail++;
      $display("FAIL full_ninth: got %0d expected 8", COUNT);
    end
    wait_quiet(ok);
    n_cmp++;
    if (!ok || wr_log.size() != 9) begin
      n_fail++;
      $display("FAIL full_writes: got %0d expected 9", wr_log.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        c = 8'h30 + 8'(i);
        n_cmp++;
        if (wr_log[i] !== c) begin
          n_fail++;
          $display("FAIL full_order[%0d]: got %h expected %h", i, wr_log[i], c);
        end
      end
    end
    n_cmp++;
    if (COL !== 4'd12) begin
      n_fail++;
      $display("FAIL full_col: got %0d expected 12", COL);
    end
  endtask

  task automatic test_line();
    bit ok;
    int bad;
    logic [7:0] c;
    apply_reset();
    tick();
    lf_count = 0;
    wr_log.delete();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      c = 8'h61 + 8'(i);
      push_wait(1'b0, c, ok);
      if (!ok) bad++;
    end
    wait_quiet(ok);
    n_cmp++;
    if (!ok || bad != 0 || wr_log.size() != 16) begin
      n_fail++;
      $display("FAIL line_writes: got %0d writes, %0d rejects expected 16/0", wr_log.size(), bad);
    end
    n_cmp++;
    if (lf_count != 1 || lf_writes != 16 || lf_col != 0) begin
      n_fail++;
      $display("FAIL line_pulse: got pulses=%0d at_write=%0d col=%0d expected 1/16/0",
               lf_count, lf_writes, lf_col);
    end
    n_cmp++;
    if (COL !== 4'd0) begin
      n_fail++;
      $display("FAIL line_col: got %0d expected 0", COL);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit found;
    int first;
    apply_reset();
    tick();
    drv_mode = M_STUCK;
    wr_log.delete();
    push_wait(1'b0, 8'h54, ok);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (LCD_WRITE) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!ok || !found) begin
      n_fail++;
      $display("FAIL to_issue: got accepted=%b issued=%b expected 1/1", ok, found);
    end
    first = 0;
    for (int k = 1; k <= TO + 5; k++) begin
      tick();
      if (ERR && first == 0) first = k;
    end
    n_cmp++;
    if (first != TO + 2) begin
      n_fail++;
      $display("FAIL to_err_cycle: got %0d expected %0d", first, TO + 2);
    end
    n_cmp++;
    if (COL !== 4'd0 || COUNT !== 4'd0 || LCD_WRITE !== 1'b0) begin
      n_fail++;
      $display("FAIL to_drop: got col=%0d count=%0d write=%b expected 0/0/0", COL, COUNT, LCD_WRITE);
    end
    drv_mode = M_NORMAL;
    push_wait(1'b0, 8'h55, ok);
    wait_quiet(ok);
    n_cmp++;
    if (!ok || COL !== 4'd1 || ERR !== 1'b1 || wr_log.size() != 2) begin
      n_fail++;
      $display("FAIL to_recover: got col=%0d err=%b writes=%0d expected 1/1/2", COL, ERR, wr_log.size());
    end
    apply_reset();
    n_cmp++;
    if (ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err_clear: got %b expected 0", ERR);
    end
  endtask

  initial begin
    RST = 1'b1;
    A_CHAR = 8'h00; B_CHAR = 8'h00;
    A_VALID = 1'b0; B_VALID = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_line();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2000000");
    $fatal(1, "watchdog expired");
  end

endmodule
